// File: rtl/vit_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | vit_layer_sequencer: runs one shared encoder block once per ViT layer,      |
// | steering ping-pong activation buffers and guarding with a timeout. Rev 1.0  |
// +----------------------------------------------------------------------------+
module vit_layer_sequencer #(
  parameter int NUM_LAYERS     = 12,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_layers_cfg,
  output logic       blk_start,
  input  logic       blk_done,
  output logic [7:0] layer_idx,
  output logic       rd_buf_sel,
  output logic       buf_wr_en,
  output logic       busy,
  output logic       done,
  output logic       out_buf_sel,
  output logic       err
);

  localparam logic [7:0]      MAX_LAYERS = 8'(NUM_LAYERS);
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    COMMIT = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [7:0]      n_layers;
  logic [TO_W-1:0] timer;
  logic            accept;
  logic            last_layer;
  logic            timer_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    accept        = (state == IDLE) && start && !abort;
    last_layer    = (layer_idx == n_layers - 8'd1);
    timer_expired = (timer == TIMER_LAST);
    state_next    = state;
    case (state)
      IDLE:    if (accept) state_next = (num_layers_cfg == 8'd0) ? FINISH : LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        if (blk_done)           state_next = COMMIT;
        else if (timer_expired) state_next = FINISH;
      end
      COMMIT:  state_next = last_layer ? FINISH : LAUNCH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && abort) state_next = IDLE;

    // Aborting suppresses the current cycle's pulses as well.
    blk_start = (state == LAUNCH) && !abort;
    buf_wr_en = (state == COMMIT) && !abort;
    done      = (state == FINISH) && !abort;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_layers    <= 8'd0;
      timer       <= '0;
      layer_idx   <= 8'd0;
      rd_buf_sel  <= 1'b0;
      out_buf_sel <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_layers   <= (num_layers_cfg > MAX_LAYERS) ? MAX_LAYERS : num_layers_cfg;
            err        <= (num_layers_cfg == 8'd0);
            layer_idx  <= 8'd0;
            rd_buf_sel <= 1'b0;
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          timer <= timer + TO_W'(1);
          if (!abort && !blk_done && timer_expired) err <= 1'b1;
        end
        COMMIT: begin
          if (!abort) begin
            rd_buf_sel <= ~rd_buf_sel;
            // Final layer wrote into the buffer opposite the one it read.
            if (last_layer) out_buf_sel <= ~rd_buf_sel;
            else            layer_idx   <= layer_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vit_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vit_layer_sequencer: directed table-driven bench for vit_layer_sequencer |
// | with a delayed-done encoder block model. Rev 1.0                            |
// +----------------------------------------------------------------------------+
module tb_vit_layer_sequencer;

  localparam int NL  = 4;
  localparam int TO  = 64;
  localparam int TOW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg = 8'd0;
  logic       blk_done;
  logic       blk_start, buf_wr_en, busy, done, out_buf_sel, err, rd_buf_sel;
  logic [7:0] layer_idx;

  logic mdl_done = 1'b0;
  logic man_done = 1'b0;
  logic mdl_en   = 1'b1;
  int   k_cfg    = 1;
  int   pend     = 0;

  int cyc = 0;
  int base = 0;
  int n_chk = 0;
  int n_fail = 0;
  int bs_t[$];
  int wr_t[$];
  int wr_li[$];
  int wr_rb[$];
  int dn_t[$];
  int dn_err, dn_obs, dn_li;

  typedef struct {
    int cfg;
    int k;
    int n_exp;
    int done_exp;
    int obs_exp;
    int err_exp;
  } vec_t;
  vec_t vecs[6];

  assign blk_done = mdl_done | man_done;

  vit_layer_sequencer #(
    .NUM_LAYERS    (NL),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (TOW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .num_layers_cfg(cfg),
    .blk_start     (blk_start),
    .blk_done      (blk_done),
    .layer_idx     (layer_idx),
    .rd_buf_sel    (rd_buf_sel),
    .buf_wr_en     (buf_wr_en),
    .busy          (busy),
    .done          (done),
    .out_buf_sel   (out_buf_sel),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder block model: blk_done k_cfg cycles after blk_start.
  always begin
    @(posedge clk);
    #1;
    mdl_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) mdl_done = 1'b1;
    end
    if (blk_start && mdl_en) pend = k_cfg;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (blk_start) bs_t.push_back(cyc - base);
      if (buf_wr_en) begin
        wr_t.push_back(cyc - base);
        wr_li.push_back(int'(layer_idx));
        wr_rb.push_back(int'(rd_buf_sel));
      end
      if (done) begin
        dn_t.push_back(cyc - base);
        dn_err = int'(err);
        dn_obs = int'(out_buf_sel);
        dn_li  = int'(layer_idx);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_rel(input int r);
    while (cyc - base < r) step(1);
  endtask

  task automatic clear_logs();
    bs_t.delete();
    wr_t.delete();
    wr_li.delete();
    wr_rb.delete();
    dn_t.delete();
  endtask

  task automatic launch(input int c);
    cfg   = 8'(c);
    start = 1'b1;
    base  = cyc;
    clear_logs();
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    while (dn_t.size() == 0 && cyc - base < limit) step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".blk_start"}, int'(blk_start), 0);
    chk({tag, ".buf_wr_en"}, int'(buf_wr_en), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".layer_idx"}, int'(layer_idx), 0);
    chk({tag, ".rd_buf_sel"}, int'(rd_buf_sel), 0);
    chk({tag, ".out_buf_sel"}, int'(out_buf_sel), 0);
    chk({tag, ".err"}, int'(err), 0);
  endtask

  initial begin
    vecs[0] = '{cfg: 3, k: 5, n_exp: 3, done_exp: 22, obs_exp: 1, err_exp: 0};
    vecs[1] = '{cfg: 0, k: 1, n_exp: 0, done_exp: 1,  obs_exp: 1, err_exp: 1};
    vecs[2] = '{cfg: 9, k: 2, n_exp: 4, done_exp: 17, obs_exp: 0, err_exp: 0};
    vecs[3] = '{cfg: 2, k: 3, n_exp: 2, done_exp: 11, obs_exp: 0, err_exp: 0};
    vecs[4] = '{cfg: 4, k: 1, n_exp: 4, done_exp: 13, obs_exp: 0, err_exp: 0};
    vecs[5] = '{cfg: 1, k: 1, n_exp: 1, done_exp: 4,  obs_exp: 1, err_exp: 0};

    // Asynchronous reset applied mid-cycle before any clock edge.
    #3 rst_n = 1'b0;
    #1 chk_all_zero("por");
    step(2);
    rst_n = 1'b1;
    base  = cyc;
    clear_logs();
    step(10);
    chk("por.no_blk_start", bs_t.size(), 0);
    chk("por.busy", int'(busy), 0);

    foreach (vecs[v]) begin
      mdl_en = 1'b1;
      k_cfg  = vecs[v].k;
      launch(vecs[v].cfg);
      wait_done(300);
      step(3);
      chk($sformatf("v%0d.n_blk_start", v), bs_t.size(), vecs[v].n_exp);
      chk($sformatf("v%0d.n_wr", v), wr_t.size(), vecs[v].n_exp);
      for (int i = 0; i < vecs[v].n_exp; i++) begin
        if (i < bs_t.size())
          chk($sformatf("v%0d.blk_start_cyc[%0d]", v, i), bs_t[i], 1 + i * (vecs[v].k + 2));
        if (i < wr_t.size()) begin
          chk($sformatf("v%0d.wr_cyc[%0d]", v, i), wr_t[i], (i + 1) * (vecs[v].k + 2));
          chk($sformatf("v%0d.layer_idx[%0d]", v, i), wr_li[i], i);
          chk($sformatf("v%0d.rd_buf_sel[%0d]", v, i), wr_rb[i], i % 2);
        end
      end
      chk($sformatf("v%0d.n_done", v), dn_t.size(), 1);
      if (dn_t.size() > 0) begin
        chk($sformatf("v%0d.done_cyc", v), dn_t[0], vecs[v].done_exp);
        chk($sformatf("v%0d.err", v), dn_err, vecs[v].err_exp);
        chk($sformatf("v%0d.out_buf_sel", v), dn_obs, vecs[v].obs_exp);
        chk($sformatf("v%0d.final_layer_idx", v), dn_li,
            (vecs[v].n_exp == 0) ? 0 : vecs[v].n_exp - 1);
      end
      chk($sformatf("v%0d.busy_after", v), int'(busy), 0);
    end

    // Timeout: block never answers.
    mdl_en = 1'b0;
    launch(2);
    goto_rel(40);
    chk("to.busy_mid", int'(busy), 1);
    wait_done(120);
    step(2);
    chk("to.n_done", dn_t.size(), 1);
    if (dn_t.size() > 0) begin
      chk("to.done_cyc", dn_t[0], 66);
      chk("to.err", dn_err, 1);
      chk("to.layer_idx", dn_li, 0);
      chk("to.out_buf_sel_held", dn_obs, 1);
    end
    chk("to.n_wr", wr_t.size(), 0);
    chk("to.n_blk_start", bs_t.size(), 1);

    // Next accepted start clears err.
    mdl_en = 1'b1;
    k_cfg  = 2;
    launch(1);
    chk("to.err_cleared", int'(err), 0);
    wait_done(100);
    step(2);
    chk("after_to.n_done", dn_t.size(), 1);
    if (dn_t.size() > 0) begin
      chk("after_to.done_cyc", dn_t[0], 5);
      chk("after_to.err", dn_err, 0);
    end

    // Abort in WAIT of layer 1, with a stray start while busy.
    k_cfg = 5;
    launch(3);
    goto_rel(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    goto_rel(10);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab.busy_next", int'(busy), 0);
    goto_rel(40);
    chk("ab.n_blk_start", bs_t.size(), 2);
    if (bs_t.size() > 1) chk("ab.blk_start_cyc1", bs_t[1], 8);
    chk("ab.n_wr", wr_t.size(), 1);
    chk("ab.n_done", dn_t.size(), 0);
    chk("ab.err", int'(err), 0);
    chk("ab.out_buf_sel", int'(out_buf_sel), 1);
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    step(1);
    chk("stray_done.busy", int'(busy), 0);
    chk("stray_done.n_wr", wr_t.size(), 1);

    // blk_done exactly in the last timer cycle counts as completion.
    mdl_en = 1'b0;
    launch(1);
    goto_rel(65);
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    goto_rel(70);
    chk("edge.n_wr", wr_t.size(), 1);
    if (wr_t.size() > 0) chk("edge.wr_cyc", wr_t[0], 66);
    chk("edge.n_done", dn_t.size(), 1);
    if (dn_t.size() > 0) begin
      chk("edge.done_cyc", dn_t[0], 67);
      chk("edge.err", dn_err, 0);
      chk("edge.out_buf_sel", dn_obs, 1);
    end

    // Reset mid-run: immediate return to IDLE, no done.
    mdl_en = 1'b1;
    k_cfg  = 5;
    launch(3);
    goto_rel(10);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    pend = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1);
    base = cyc;
    clear_logs();
    step(10);
    chk("midrst.n_blk_start", bs_t.size(), 0);
    chk("midrst.n_done", dn_t.size(), 0);
    chk("midrst.busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
